// File: rtl/inst_queue.sv
// Instruction queue between decode and issue: 2-wide push, 0/1/2-entry pop,
// head/head+1 presented as NOP-gated output slots.
`ifndef WIDTH_UOP
`define WIDTH_UOP 16
`endif

module inst_queue #(
   parameter int unsigned WIDTH_UOP = `WIDTH_UOP,
   parameter int unsigned DEPTH     = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 flush,
   input  logic [1:0]           in_valid,
   output logic                 in_ready,
   input  logic [WIDTH_UOP-1:0] in_uop0,
   input  logic [WIDTH_UOP-1:0] in_uop1,
   input  logic [4:0]           in_rd0,
   input  logic [4:0]           in_rj0,
   input  logic [4:0]           in_rk0,
   input  logic [4:0]           in_rd1,
   input  logic [4:0]           in_rj1,
   input  logic [4:0]           in_rk1,
   input  logic [31:0]          in_imm0,
   input  logic [31:0]          in_imm1,
   input  logic [6:0]           in_exception0,
   input  logic [6:0]           in_exception1,
   input  logic [31:0]          in_pc0,
   input  logic [31:0]          in_pc_next0,
   input  logic [31:0]          in_pc1,
   input  logic [31:0]          in_pc_next1,
   output logic [WIDTH_UOP-1:0] uop0,
   output logic [WIDTH_UOP-1:0] uop1,
   output logic [4:0]           rd0,
   output logic [4:0]           rj0,
   output logic [4:0]           rk0,
   output logic [4:0]           rd1,
   output logic [4:0]           rj1,
   output logic [4:0]           rk1,
   output logic [31:0]          imm0,
   output logic [31:0]          imm1,
   output logic [6:0]           exception0,
   output logic [6:0]           exception1,
   output logic [31:0]          pc0,
   output logic [31:0]          pc_next0,
   output logic [31:0]          pc1,
   output logic [31:0]          pc_next1,
   input  logic [1:0]           num_read
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = 32 + 32 + 7 + 32 + 15 + WIDTH_UOP;
   localparam logic [ENT_W-1:0] NOP_ENT = {32'd4, {(ENT_W-32){1'b0}}};

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W-1:0] head_p1, tail_p1;
   logic [CNT_W-1:0] count;
   logic [1:0]       push_n, pop_n;
   logic [ENT_W-1:0] wr0, wr1, ent0, ent1;

   assign head_p1  = head + PTR_W'(1);
   assign tail_p1  = tail + PTR_W'(1);
   assign in_ready = (count <= CNT_W'(DEPTH - 2));

   assign wr0 = {in_pc_next0, in_pc0, in_exception0, in_imm0, in_rd0, in_rk0, in_rj0, in_uop0};
   assign wr1 = {in_pc_next1, in_pc1, in_exception1, in_imm1, in_rd1, in_rk1, in_rj1, in_uop1};

   always_comb begin
      push_n = 2'd0;
      if (in_ready) begin
         if (in_valid == 2'b01)      push_n = 2'd1;
         else if (in_valid == 2'b11) push_n = 2'd2;
      end
   end

   // Pops saturate at the number of valid entries so NOP filler never underflows.
   always_comb begin
      pop_n = 2'd0;
      if (num_read == 2'b01) begin
         pop_n = (count >= CNT_W'(1)) ? 2'd1 : 2'd0;
      end else if (num_read == 2'b11) begin
         if (count >= CNT_W'(2))      pop_n = 2'd2;
         else if (count == CNT_W'(1)) pop_n = 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(pop_n);
         tail  <= tail + PTR_W'(push_n);
         count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
      end
   end

   always_ff @(posedge clk) begin
      if (rstn && !flush) begin
         if (push_n != 2'd0) mem[tail]    <= wr0;
         if (push_n == 2'd2) mem[tail_p1] <= wr1;
      end
   end

   assign ent0 = (count >= CNT_W'(1)) ? mem[head]    : NOP_ENT;
   assign ent1 = (count >= CNT_W'(2)) ? mem[head_p1] : NOP_ENT;

   assign {pc_next0, pc0, exception0, imm0, rd0, rk0, rj0, uop0} = ent0;
   assign {pc_next1, pc1, exception1, imm1, rd1, rk1, rj1, uop1} = ent1;

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter WIDTH_UOP, default `WIDTH_UOP, the micro-op width shared with the issue stage.
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of two, at least 4.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have port in_valid  input  2  push request; 00 none, 01 push in slot 0 only, 11 push slot 0 then slot 1, 10 illegal.
REQ-007 SHALL have port in_ready  output  1  queue accepts a 2-wide push this cycle.
REQ-008 SHALL have ports in_uop0/in_uop1  input  WIDTH_UOP  decoded micro-ops.
REQ-009 SHALL have ports in_rd0/rj0/rk0/rd1/rj1/rk1  input  5 each  register indices.
REQ-010 SHALL have ports in_imm0/in_imm1  input  32  immediates.
REQ-011 SHALL have ports in_exception0/1  input  7  exception codes.
REQ-012 SHALL have ports in_pc0/in_pc_next0/in_pc1/in_pc_next1  input  32 each.
REQ-013 SHALL have ports uop0/uop1, rd0/rj0/rk0/rd1/rj1/rk1, imm0/imm1, exception0/1, pc0/pc_next0/pc1/pc_next1  output  same widths  head and head+1 entries presented to the issue stage.
REQ-014 SHALL have port num_read  input  2  entries consumed by the issue stage; 00 none, 01 one, 11 two, 10 illegal.

Function
REQ-015 SHALL store each entry as {pc_next, pc, exception, imm, rd, rk, rj, uop} in a circular buffer with a head pointer, a tail pointer (log2(DEPTH) bits, wrapping modulo DEPTH) and a count of log2(DEPTH)+1 bits.
REQ-016 SHALL drive output slot 0 from entry head when count>=1, otherwise with the NOP pattern.
REQ-017 SHALL drive output slot 1 from entry head+1 (mod DEPTH) when count>=2, otherwise with the NOP pattern.
REQ-018 NOP pattern: uop=0 (type field 0), rd=rj=rk=0, imm=0, exception=0, pc=0, pc_next=4.
REQ-019 SHALL drive all outputs only from registered state; no combinational path from in_* or num_read to outputs or in_ready.
REQ-020 SHALL derive in_ready as (DEPTH - count) >= 2 from the registered count, ignoring same-cycle pops.
REQ-021 Push: when in_ready=1 and in_valid=01, SHALL write slot 0 at tail and set tail+=1; when in_valid=11, SHALL write slot 0 at tail and slot 1 at tail+1, then set tail+=2.
REQ-022 When in_ready=0 SHALL ignore in_valid; in_valid=10 SHALL be ignored; the producer holds data.
REQ-023 Pop count SHALL be min(1,count) for num_read=01, min(2,count) for 11, and 0 for 00 or 10; head advances by the pop count.
REQ-024 Popping NOP filler (count<requested) SHALL NOT underflow; head and count saturate at the valid entries.
REQ-025 Simultaneous push and pop in one cycle: count_next = count + pushed - popped, evaluated from pre-edge count; entries pushed this cycle become visible on outputs next cycle (no bypass).
REQ-026 Wrap-around: a 2-wide push or pop straddling index DEPTH-1 to 0 SHALL keep entry order.
REQ-027 flush SHALL have priority over push and pop: head=tail=count=0 next cycle; same-cycle push discarded.

Reset
REQ-028 With rstn=0 at a clock edge, head=tail=count=0 and both output slots SHALL show the NOP pattern from the next cycle; in_ready=1 after reset.
REQ-029 Storage array contents need not be reset; outputs SHALL never expose stale entries because slots gate on count.

Verification
REQ-030 Reset, then in_valid=11 with pc0=0x1c000000 and pc1=0x1c000004, num_read=00 -> next cycle count=2, pc0=0x1c000000, pc1=0x1c000004, in_ready=1.
REQ-031 Fill 8 entries with no pops -> in_ready=0 at count=8 (and at count=7); further in_valid=11 ignored; num_read=11 -> count=6, in_ready=1 next cycle.
REQ-032 Count=1 with num_read=11 and in_valid=11 same cycle -> count=2, slot0 = first new entry; before the edge slot1 showed NOP (uop=0, pc_next=4).
REQ-033 Head at index 7 with count=3, num_read=11 -> slot0 = old entry at index 1, count=1; order preserved across the wrap.
REQ-034 Count=5 with flush=1, in_valid=11 and num_read=01 -> next cycle count=0, both slots NOP, in_ready=1.
REQ-035 Random push/pop for 10k cycles against a reference queue -> output slots and count match every cycle, with no lost or duplicated entries.
